// File: rtl/rs_multi_cdb.sv
// Reservation station with CDB_NUM wakeup buses, one issue port, branch squash and occupancy count.
// Optional macro RS_AGE_SEL_EN: age-matrix select (oldest ready) instead of lowest-index ready.
module rs_multi_cdb #(
    parameter int RS_DEPTH    = 8,
    parameter int PRF_IDX_W   = 6,
    parameter int RS_OPCODE_W = 5,
    parameter int CDB_NUM     = 2,
    parameter int CNT_W       = $clog2(RS_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [PRF_IDX_W-1:0]         rat_dest_tag_i,
    input  logic [PRF_IDX_W-1:0]         rat_opa_tag_i,
    input  logic [PRF_IDX_W-1:0]         rat_opb_tag_i,
    input  logic                         rat_opa_rdy_i,
    input  logic                         rat_opb_rdy_i,
    input  logic                         id_inst_vld_i,
    input  logic [RS_OPCODE_W-1:0]       id_opcode_i,
    input  logic [CDB_NUM*PRF_IDX_W-1:0] cdb_tag_i,
    input  logic [CDB_NUM-1:0]           cdb_vld_i,
    input  logic                         stall_dp_i,
    input  logic                         fu_rdy_i,
    input  logic                         br_flush_i,
    output logic                         rs_iss_vld_o,
    output logic [PRF_IDX_W-1:0]         rs_iss_opa_tag_o,
    output logic [PRF_IDX_W-1:0]         rs_iss_opb_tag_o,
    output logic [PRF_IDX_W-1:0]         rs_iss_dest_tag_o,
    output logic [RS_OPCODE_W-1:0]       rs_iss_opcode_o,
    output logic                         rs_full_o,
    output logic [CNT_W-1:0]             rs_cnt_o
);
    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0]    r_vld;
    logic [RS_DEPTH-1:0]    r_opa_rdy;
    logic [RS_DEPTH-1:0]    r_opb_rdy;
    logic [PRF_IDX_W-1:0]   r_dest    [RS_DEPTH];
    logic [PRF_IDX_W-1:0]   r_opa_tag [RS_DEPTH];
    logic [PRF_IDX_W-1:0]   r_opb_tag [RS_DEPTH];
    logic [RS_OPCODE_W-1:0] r_opcode  [RS_DEPTH];
    logic [CNT_W-1:0]       r_cnt;

    logic                   w_disp;
    logic                   w_issue;
    logic                   w_any_rdy;
    logic [RS_DEPTH-1:0]    w_rdy;
    logic [RS_DEPTH-1:0]    w_sel_cand;
    logic [RS_DEPTH-1:0]    w_opa_wake;
    logic [RS_DEPTH-1:0]    w_opb_wake;
    logic                   w_new_opa_hit;
    logic                   w_new_opb_hit;
    logic [IDX_W-1:0]       w_free_idx;
    logic [IDX_W-1:0]       w_sel_idx;

    // Full is taken from the registered valid vector, so a slot freed by this cycle's issue is not reused until next cycle.
    assign rs_full_o = &r_vld;
    assign rs_cnt_o  = r_cnt;
    assign w_disp    = id_inst_vld_i & ~stall_dp_i & ~rs_full_o;
    assign w_rdy     = r_vld & r_opa_rdy & r_opb_rdy;
    assign w_any_rdy = |w_rdy;
    assign w_issue   = w_any_rdy & fu_rdy_i;

    // NOTE: every always_comb output gets a default before any conditional write, so no latch is inferred.
    always_comb begin
        w_opa_wake    = '0;
        w_opb_wake    = '0;
        w_new_opa_hit = 1'b0;
        w_new_opb_hit = 1'b0;
        for (int k = 0; k < CDB_NUM; k++) begin
            if (cdb_vld_i[k]) begin
                for (int e = 0; e < RS_DEPTH; e++) begin
                    if (r_opa_tag[e] == cdb_tag_i[k*PRF_IDX_W +: PRF_IDX_W]) w_opa_wake[e] = 1'b1;
                    if (r_opb_tag[e] == cdb_tag_i[k*PRF_IDX_W +: PRF_IDX_W]) w_opb_wake[e] = 1'b1;
                end
                if (rat_opa_tag_i == cdb_tag_i[k*PRF_IDX_W +: PRF_IDX_W]) w_new_opa_hit = 1'b1;
                if (rat_opb_tag_i == cdb_tag_i[k*PRF_IDX_W +: PRF_IDX_W]) w_new_opb_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_free_idx = '0;
        for (int e = RS_DEPTH - 1; e >= 0; e--) begin
            if (!r_vld[e]) w_free_idx = IDX_W'(e);
        end
    end

`ifdef RS_AGE_SEL_EN
    // r_age[i][j] = 1 means entry i was dispatched after entry j.
    logic [RS_DEPTH-1:0] r_age [RS_DEPTH];

    always_ff @(posedge clk) begin
        if (rst || br_flush_i) begin
            for (int e = 0; e < RS_DEPTH; e++) r_age[e] <= '0;
        end else if (w_disp) begin
            for (int e = 0; e < RS_DEPTH; e++) begin
                if (IDX_W'(e) == w_free_idx) r_age[e] <= r_vld;
                else                         r_age[e][w_free_idx] <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            w_sel_cand[e] = w_rdy[e] & ~|(r_age[e] & w_rdy);
        end
    end
`else
    assign w_sel_cand = w_rdy;
`endif

    always_comb begin
        w_sel_idx = '0;
        for (int e = RS_DEPTH - 1; e >= 0; e--) begin
            if (w_sel_cand[e]) w_sel_idx = IDX_W'(e);
        end
    end

    assign rs_iss_vld_o      = w_any_rdy;
    assign rs_iss_opa_tag_o  = w_any_rdy ? r_opa_tag[w_sel_idx] : '0;
    assign rs_iss_opb_tag_o  = w_any_rdy ? r_opb_tag[w_sel_idx] : '0;
    assign rs_iss_dest_tag_o = w_any_rdy ? r_dest[w_sel_idx]    : '0;
    assign rs_iss_opcode_o   = w_any_rdy ? r_opcode[w_sel_idx]  : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || br_flush_i) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            if (w_issue) r_vld[w_sel_idx] <= 1'b0;
            if (w_disp)  r_vld[w_free_idx] <= 1'b1;
            r_cnt <= r_cnt + CNT_W'(w_disp) - CNT_W'(w_issue);
        end
    end

    // NOTE: payload and ready bits carry no reset; they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        for (int e = 0; e < RS_DEPTH; e++) begin
            if (w_opa_wake[e]) r_opa_rdy[e] <= 1'b1;
            if (w_opb_wake[e]) r_opb_rdy[e] <= 1'b1;
        end
        if (w_disp) begin
            r_dest[w_free_idx]    <= rat_dest_tag_i;
            r_opa_tag[w_free_idx] <= rat_opa_tag_i;
            r_opb_tag[w_free_idx] <= rat_opb_tag_i;
            r_opcode[w_free_idx]  <= id_opcode_i;
            r_opa_rdy[w_free_idx] <= rat_opa_rdy_i | w_new_opa_hit;
            r_opb_rdy[w_free_idx] <= rat_opb_rdy_i | w_new_opb_hit;
        end
    end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Self-checking bench for rs_multi_cdb: directed scenarios then random traffic against a slot/sequence-number model.
module tb_rs_multi_cdb;
    localparam int DEPTH = 8;
    localparam int TW    = 6;
    localparam int OW    = 5;
    localparam int NCDB  = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [TW-1:0]     rat_dest_tag_i, rat_opa_tag_i, rat_opb_tag_i;
    logic              rat_opa_rdy_i, rat_opb_rdy_i;
    logic              id_inst_vld_i;
    logic [OW-1:0]     id_opcode_i;
    logic [NCDB*TW-1:0] cdb_tag_i;
    logic [NCDB-1:0]   cdb_vld_i;
    logic              stall_dp_i, fu_rdy_i, br_flush_i;
    logic              rs_iss_vld_o;
    logic [TW-1:0]     rs_iss_opa_tag_o, rs_iss_opb_tag_o, rs_iss_dest_tag_o;
    logic [OW-1:0]     rs_iss_opcode_o;
    logic              rs_full_o;
    logic [CW-1:0]     rs_cnt_o;

    rs_multi_cdb #(.RS_DEPTH(DEPTH), .PRF_IDX_W(TW), .RS_OPCODE_W(OW), .CDB_NUM(NCDB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .rat_dest_tag_i(rat_dest_tag_i), .rat_opa_tag_i(rat_opa_tag_i), .rat_opb_tag_i(rat_opb_tag_i),
        .rat_opa_rdy_i(rat_opa_rdy_i), .rat_opb_rdy_i(rat_opb_rdy_i),
        .id_inst_vld_i(id_inst_vld_i), .id_opcode_i(id_opcode_i),
        .cdb_tag_i(cdb_tag_i), .cdb_vld_i(cdb_vld_i),
        .stall_dp_i(stall_dp_i), .fu_rdy_i(fu_rdy_i), .br_flush_i(br_flush_i),
        .rs_iss_vld_o(rs_iss_vld_o), .rs_iss_opa_tag_o(rs_iss_opa_tag_o),
        .rs_iss_opb_tag_o(rs_iss_opb_tag_o), .rs_iss_dest_tag_o(rs_iss_dest_tag_o),
        .rs_iss_opcode_o(rs_iss_opcode_o), .rs_full_o(rs_full_o), .rs_cnt_o(rs_cnt_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: an unordered set of slots, each stamped with a dispatch sequence number for age ordering.
    bit          m_vld   [DEPTH];
    bit          m_a_rdy [DEPTH];
    bit          m_b_rdy [DEPTH];
    logic [TW-1:0] m_dest [DEPTH];
    logic [TW-1:0] m_a_tag[DEPTH];
    logic [TW-1:0] m_b_tag[DEPTH];
    logic [OW-1:0] m_op   [DEPTH];
    int unsigned m_seq   [DEPTH];
    int unsigned seq_ctr = 0;

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(m_vld[i]);
        return c;
    endfunction

    function automatic int m_sel();
        int best = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_vld[i] && m_a_rdy[i] && m_b_rdy[i]) begin
`ifdef RS_AGE_SEL_EN
                if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    function automatic bit cdb_hit(input logic [TW-1:0] tag);
        for (int k = 0; k < NCDB; k++)
            if (cdb_vld_i[k] && cdb_tag_i[k*TW +: TW] == tag) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_update();
        int sel  = m_sel();
        int free = -1;
        bit full = (m_count() == DEPTH);
        for (int i = 0; i < DEPTH; i++) if (!m_vld[i] && free < 0) free = i;
        if (rst || br_flush_i) begin
            for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cdb_hit(m_a_tag[i])) m_a_rdy[i] = 1'b1;
                if (cdb_hit(m_b_tag[i])) m_b_rdy[i] = 1'b1;
            end
            if (sel >= 0 && fu_rdy_i) m_vld[sel] = 1'b0;
            if (id_inst_vld_i && !stall_dp_i && !full) begin
                m_vld[free]   = 1'b1;
                m_dest[free]  = rat_dest_tag_i;
                m_a_tag[free] = rat_opa_tag_i;
                m_b_tag[free] = rat_opb_tag_i;
                m_op[free]    = id_opcode_i;
                m_a_rdy[free] = rat_opa_rdy_i || cdb_hit(rat_opa_tag_i);
                m_b_rdy[free] = rat_opb_rdy_i || cdb_hit(rat_opb_tag_i);
                m_seq[free]   = seq_ctr++;
            end
        end
    endtask

    task automatic compare();
        int sel = m_sel();
        int cnt = m_count();
        check("iss_vld", 32'(rs_iss_vld_o), 32'(sel >= 0));
        check("iss_dest", 32'(rs_iss_dest_tag_o), sel >= 0 ? 32'(m_dest[sel])  : 32'd0);
        check("iss_opa",  32'(rs_iss_opa_tag_o),  sel >= 0 ? 32'(m_a_tag[sel]) : 32'd0);
        check("iss_opb",  32'(rs_iss_opb_tag_o),  sel >= 0 ? 32'(m_b_tag[sel]) : 32'd0);
        check("iss_op",   32'(rs_iss_opcode_o),   sel >= 0 ? 32'(m_op[sel])    : 32'd0);
        check("cnt",  32'(rs_cnt_o),  32'(cnt));
        check("full", 32'(rs_full_o), 32'(cnt == DEPTH));
    endtask

    // Inputs are driven at the negedge; the model steps, the DUT clocks, outputs are checked at the next negedge.
    task automatic tick();
        model_update();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        rst = 1'b0; id_inst_vld_i = 1'b0; stall_dp_i = 1'b0; fu_rdy_i = 1'b0; br_flush_i = 1'b0;
        rat_dest_tag_i = '0; rat_opa_tag_i = '0; rat_opb_tag_i = '0;
        rat_opa_rdy_i = 1'b0; rat_opb_rdy_i = 1'b0; id_opcode_i = '0;
        cdb_tag_i = '0; cdb_vld_i = '0;
    endtask

    task automatic disp(input logic [TW-1:0] d, input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input bit ar, input bit br, input logic [OW-1:0] op);
        id_inst_vld_i = 1'b1; rat_dest_tag_i = d; rat_opa_tag_i = a; rat_opb_tag_i = b;
        rat_opa_rdy_i = ar; rat_opb_rdy_i = br; id_opcode_i = op;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick(); tick();
        check("rst_cnt", 32'(rs_cnt_o), 32'd0);
        check("rst_vld", 32'(rs_iss_vld_o), 32'd0);

        // Single ready dispatch issues the next cycle, count 1 -> 0
        idle(); disp(6'h2A, 6'h01, 6'h02, 1, 1, 5'd3); fu_rdy_i = 1'b1;
        tick();
        check("t1_vld", 32'(rs_iss_vld_o), 32'd1);
        check("t1_dest", 32'(rs_iss_dest_tag_o), 32'h2A);
        check("t1_cnt1", 32'(rs_cnt_o), 32'd1);
        idle(); fu_rdy_i = 1'b1;
        tick();
        check("t1_cnt0", 32'(rs_cnt_o), 32'd0);

        // Fill with non-ready entries; entry 0 waits on opa tag 0x12
        for (int i = 0; i < DEPTH; i++) begin
            idle(); disp(6'(8'h20 + i), i == 0 ? 6'h12 : 6'(8'h30 + i), 6'h3F, 0, i == 0, 5'(i));
            tick();
        end
        check("fill_full", 32'(rs_full_o), 32'd1);
        check("fill_cnt", 32'(rs_cnt_o), 32'd8);
        idle(); disp(6'h11, 6'h00, 6'h00, 1, 1, 5'd1);
        tick();
        check("drop_cnt", 32'(rs_cnt_o), 32'd8);

        // Wakeup on CDB port 1: not visible in the same cycle, visible after the edge
        idle(); cdb_vld_i = 2'b10; cdb_tag_i = {6'h12, 6'h00};
        check("wake_same", 32'(rs_iss_vld_o), 32'd0);
        tick();
        check("wake_next", 32'(rs_iss_vld_o), 32'd1);
        check("wake_dest", 32'(rs_iss_dest_tag_o), 32'h20);

        // Full: issue and dispatch together -> dispatch rejected, then accepted
        idle(); fu_rdy_i = 1'b1; disp(6'h15, 6'h00, 6'h00, 0, 0, 5'd2);
        tick();
        check("fi_cnt7", 32'(rs_cnt_o), 32'd7);
        idle(); disp(6'h16, 6'h00, 6'h00, 0, 0, 5'd2);
        tick();
        check("fi_cnt8", 32'(rs_cnt_o), 32'd8);

        // Flush, rebuild 5 ready entries, flush alongside a dispatch
        idle(); br_flush_i = 1'b1; tick();
        for (int i = 0; i < 5; i++) begin
            idle(); disp(6'(i), 6'h00, 6'h00, 1, 1, 5'd0); tick();
        end
        idle(); br_flush_i = 1'b1; fu_rdy_i = 1'b1; disp(6'h19, 6'h00, 6'h00, 1, 1, 5'd0);
        tick();
        check("fl_cnt", 32'(rs_cnt_o), 32'd0);
        check("fl_vld", 32'(rs_iss_vld_o), 32'd0);

        // Dispatch bypass: opb tag 0x07 matches CDB port 0 in the dispatch cycle
        idle(); disp(6'h33, 6'h00, 6'h07, 1, 0, 5'd9); cdb_vld_i = 2'b01; cdb_tag_i = {6'h00, 6'h07};
        tick();
        check("byp_vld", 32'(rs_iss_vld_o), 32'd1);
        check("byp_dest", 32'(rs_iss_dest_tag_o), 32'h33);
        idle(); fu_rdy_i = 1'b1; tick();

        // Age ordering: A lands in entry 1, B later in entry 0, both ready together
        idle(); disp(6'h01, 6'h00, 6'h00, 1, 1, 5'd0); tick();
        idle(); disp(6'h0A, 6'h21, 6'h00, 0, 1, 5'd0); tick();
        idle(); fu_rdy_i = 1'b1; tick();
        idle(); disp(6'h0B, 6'h00, 6'h00, 1, 1, 5'd0); cdb_vld_i = 2'b01; cdb_tag_i = {6'h00, 6'h21};
        tick();
`ifdef RS_AGE_SEL_EN
        check("age_first", 32'(rs_iss_dest_tag_o), 32'h0A);
`else
        check("age_first", 32'(rs_iss_dest_tag_o), 32'h0B);
`endif
        idle(); fu_rdy_i = 1'b1; tick(); tick();

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            rst            = ($urandom_range(0, 99) == 0);
            br_flush_i     = ($urandom_range(0, 24) == 0);
            stall_dp_i     = ($urandom_range(0, 9) == 0);
            fu_rdy_i       = ($urandom_range(0, 9) < 5);
            id_inst_vld_i  = ($urandom_range(0, 9) < 7);
            rat_dest_tag_i = 6'($urandom);
            rat_opa_tag_i  = 6'($urandom_range(0, 15));
            rat_opb_tag_i  = 6'($urandom_range(0, 15));
            rat_opa_rdy_i  = ($urandom_range(0, 9) < 3);
            rat_opb_rdy_i  = ($urandom_range(0, 9) < 3);
            id_opcode_i    = 5'($urandom);
            cdb_vld_i      = 2'($urandom);
            cdb_tag_i      = {6'($urandom_range(0, 15)), 6'($urandom_range(0, 15))};
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
- Parametrised reservation station, next generation of the single-CDB RS. Sits between dispatch (RAT/decode) and one functional-unit issue port.
- Holds up to RS_DEPTH renamed instructions and wakes operands from CDB_NUM broadcast buses.
- Issues one ready instruction per cycle when the FU accepts it.
- Supports whole-station squash on branch mispredict and reports an occupancy count for dispatch throttling.

Parameters:
- RS_DEPTH, 8, number of entries; power of two, at least 2.
- PRF_IDX_W, 6, physical register tag width.
- RS_OPCODE_W, 5, opcode field width.
- CDB_NUM, 2, number of CDB broadcast ports.
- CNT_W, $clog2(RS_DEPTH+1), width of the occupancy count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rat_dest_tag_i  in  PRF_IDX_W  destination physical tag of the dispatching instruction.
- rat_opa_tag_i  in  PRF_IDX_W  operand A tag.
- rat_opb_tag_i  in  PRF_IDX_W  operand B tag.
- rat_opa_rdy_i  in  1  operand A already available at rename.
- rat_opb_rdy_i  in  1  operand B already available at rename.
- id_inst_vld_i  in  1  dispatch request.
- id_opcode_i  in  RS_OPCODE_W  opcode.
- cdb_tag_i  in  CDB_NUM*PRF_IDX_W  broadcast tags; port k occupies bits [k*PRF_IDX_W +: PRF_IDX_W].
- cdb_vld_i  in  CDB_NUM  per-port broadcast valid.
- stall_dp_i  in  1  global dispatch stall.
- fu_rdy_i  in  1  FU accepts an issue this cycle.
- br_flush_i  in  1  mispredict squash.
- rs_iss_vld_o  out  1  issue valid.
- rs_iss_opa_tag_o  out  PRF_IDX_W  issued operand A tag.
- rs_iss_opb_tag_o  out  PRF_IDX_W  issued operand B tag.
- rs_iss_dest_tag_o  out  PRF_IDX_W  issued destination tag.
- rs_iss_opcode_o  out  RS_OPCODE_W  issued opcode.
- rs_full_o  out  1  all entries valid.
- rs_cnt_o  out  CNT_W  number of valid entries.

Behaviour:
- Entry state: vld, opcode, dest, opa/opb tag, opa/opb rdy. All registered.
- Reset (rst=1 at an edge): every vld=0. Then rs_full_o=0, rs_cnt_o=0, rs_iss_vld_o=0. Tag and opcode outputs read as 0 while rs_iss_vld_o=0.
- Reset wins over any simultaneous dispatch, issue or flush.
- Dispatch fires when id_inst_vld_i & !stall_dp_i & !rs_full_o.
  - Writes the lowest-index free entry at the edge.
  - rs_full_o is computed from registered vld only; a slot freed by issue in the same cycle is not reusable until the next cycle.
  - Dispatch while full is silently dropped; upstream must honour rs_full_o.
- Wakeup: an operand rdy sets at the edge when cdb_vld_i[k] and cdb_tag_i[k] equals the stored tag, for any k. Multiple matching ports are harmless.
- Dispatch bypass: an incoming operand is stored ready if rat_*_rdy_i is set or it matches any valid CDB port in that cycle.
- Ready entry: vld & opa_rdy & opb_rdy, from registered state only. An entry woken at edge t can first issue in cycle t+1 (one-cycle wakeup-to-issue).
- Select (combinational) picks the lowest-index ready entry. rs_iss_vld_o=1 when any entry is ready, independent of fu_rdy_i; outputs show that entry's fields.
- Issue handshake: rs_iss_vld_o & fu_rdy_i → the selected entry's vld clears at the edge. Without fu_rdy_i the entry stays and the outputs hold.
- Count: rs_cnt_o = popcount(vld), registered.
  - Dispatch and issue in the same cycle: count unchanged.
  - Count saturates at RS_DEPTH, with rs_full_o=1 exactly when rs_cnt_o==RS_DEPTH.
- Flush: br_flush_i=1 clears all vld at the edge and overrides a same-cycle dispatch (dropped) and wakeup. rs_iss_vld_o is still driven combinationally in the flush cycle; the FU must ignore it when br_flush_i=1.
- No FSM beyond per-entry valid/ready bits. Occupancy is the only counter.

Optional Feature:
- Macro: RS_AGE_SEL_EN.
- Defined: an RS_DEPTH×RS_DEPTH age matrix is maintained.
  - On dispatch into entry i, row i is set to the current vld vector (i is younger than all current entries) and column i is cleared.
  - Select picks the oldest ready entry.
  - Flush and reset clear the matrix.
- Undefined: no matrix; select is lowest-index ready.

Test Plan:
- Reset, then 1 dispatch with opa_rdy=opb_rdy=1, fu_rdy_i=1 → issue next cycle, dest tag matches, rs_cnt_o 1→0.
- Fill 8 entries with non-ready tags, then assert id_inst_vld_i → rs_full_o=1, 9th dispatch dropped, rs_cnt_o stays 8.
- Entry waits on opa tag 0x12; drive cdb port 1 with tag 0x12 → rdy at the edge, rs_iss_vld_o=1 the next cycle, not the same cycle.
- Dispatch with opb tag 0x07 while cdb port 0 broadcasts 0x07 → stored ready, issues the following cycle.
- Full RS, then issue and dispatch in the same cycle → dispatch rejected, count becomes 7; the next cycle's dispatch is accepted.
- 5 entries valid plus a dispatch, with br_flush_i=1 → rs_cnt_o=0 and rs_iss_vld_o=0 next cycle.
- With RS_AGE_SEL_EN: dispatch A into entry 1, then B into entry 0, both ready → A issues before B.
